ht_decode: RTL and testbench

HT_DECODE -- requirements
Module: ht_decode

---
 rtl/ht_pkg.sv | 27 ++
 rtl/ht_min2_select.sv | 47 ++++
 rtl/ht_decode.sv | 132 +++++++++++++
 tb/tb_ht_decode.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ht_pkg.sv
// Shared Huffman definitions: sizes, symbol alphabet, controller states and
// the node ordering key used by both encoder and decoder.
package ht_pkg;

  localparam int NUM_SYM  = 8;
  localparam int NODE_W   = 4;
  localparam int WEIGHT_W = 6;
  localparam int NUM_NODE = 2 * NUM_SYM - 1;
  localparam int KEY_W    = WEIGHT_W + NODE_W;

  localparam logic [NODE_W-1:0] ROOT_ID = NODE_W'(NUM_NODE - 1);

  typedef enum logic [2:0] {
    SYM_A, SYM_B, SYM_C, SYM_E, SYM_I, SYM_L, SYM_O, SYM_V
  } sym_t;

  typedef enum logic [1:0] {
    IDLE, LOAD, BUILD, DECODE
  } state_t;

  // Weight dominates, node id breaks ties, so every key is unique.
  function automatic logic [KEY_W-1:0] node_key(input logic [WEIGHT_W-1:0] w,
                                                input logic [NODE_W-1:0] id);
    return {w, id};
  endfunction

endpackage

// File: rtl/ht_min2_select.sv
// Combinational search for the two smallest active nodes by (weight, id).
module ht_min2_select
  import ht_pkg::*;
(
  input  logic [NUM_NODE*WEIGHT_W-1:0] weights,
  input  logic [NUM_NODE-1:0]          active,
  output logic [NODE_W-1:0]            min_id,
  output logic [NODE_W-1:0]            second_id
);

  logic [KEY_W-1:0] key [NUM_NODE];
  logic             found1;
  logic             found2;
  logic [KEY_W-1:0] key1;
  logic [KEY_W-1:0] key2;

  generate
    for (genvar gi = 0; gi < NUM_NODE; gi++) begin : g_key
      assign key[gi] = node_key(weights[gi*WEIGHT_W +: WEIGHT_W], NODE_W'(gi));
    end
  endgenerate

  // Two linear scans: first finds the minimum, second skips it.
  always_comb begin
    min_id    = '0;
    second_id = '0;
    found1    = 1'b0;
    found2    = 1'b0;
    key1      = '1;
    key2      = '1;
    for (int i = 0; i < NUM_NODE; i++) begin
      if (active[i] && (!found1 || key[i] < key1)) begin
        found1 = 1'b1;
        key1   = key[i];
        min_id = NODE_W'(i);
      end
    end
    for (int i = 0; i < NUM_NODE; i++) begin
      if (active[i] && (NODE_W'(i) != min_id) && (!found2 || key[i] < key2)) begin
        found2    = 1'b1;
        key2      = key[i];
        second_id = NODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/ht_decode.sv
// Huffman decoder: loads 8 symbol weights, builds the tree one merge per
// cycle, then walks the tree one code bit per cycle emitting symbols.
module ht_decode
  import ht_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [2:0] in_weight,
  input  logic       code_valid,
  input  logic       code_bit,
  output logic       ready,
  output logic       out_valid,
  output logic [2:0] out_symbol
);

  state_t              state_reg;
  logic [3:0]          load_cnt_reg;
  logic [2:0]          merge_cnt_reg;
  logic [NODE_W-1:0]   pos_reg;
  logic [NUM_NODE-1:0] active_reg;
  logic [WEIGHT_W-1:0] weight_reg [NUM_NODE];
  logic [NODE_W-1:0]   child0_reg [NUM_NODE];
  logic [NODE_W-1:0]   child1_reg [NUM_NODE];
  logic                leaf_reg   [NUM_NODE];

  logic [NUM_NODE*WEIGHT_W-1:0] weights_flat;
  logic [NODE_W-1:0]            min_id;
  logic [NODE_W-1:0]            second_id;
  logic [NODE_W-1:0]            new_id;
  logic [WEIGHT_W-1:0]          sum_weight;
  logic [NODE_W-1:0]            next_node;

  generate
    for (genvar gi = 0; gi < NUM_NODE; gi++) begin : g_flat
      assign weights_flat[gi*WEIGHT_W +: WEIGHT_W] = weight_reg[gi];
    end
  endgenerate

  ht_min2_select u_min2 (
    .weights   (weights_flat),
    .active    (active_reg),
    .min_id    (min_id),
    .second_id (second_id)
  );

  assign new_id     = NODE_W'(NUM_SYM) + NODE_W'(merge_cnt_reg);
  assign sum_weight = weight_reg[min_id] + weight_reg[second_id];
  assign next_node  = code_bit ? child1_reg[pos_reg] : child0_reg[pos_reg];

  // Controller, tree storage and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      load_cnt_reg  <= '0;
      merge_cnt_reg <= '0;
      pos_reg       <= ROOT_ID;
      active_reg    <= '0;
      ready         <= 1'b0;
      out_valid     <= 1'b0;
      out_symbol    <= '0;
      for (int i = 0; i < NUM_NODE; i++) begin
        weight_reg[i] <= '0;
        child0_reg[i] <= '0;
        child1_reg[i] <= '0;
        leaf_reg[i]   <= 1'b0;
      end
    end else begin
      out_valid  <= 1'b0;
      out_symbol <= '0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            // First weight lands as symbol 0; all leaves become candidates.
            weight_reg[0] <= {3'b000, in_weight};
            load_cnt_reg  <= 4'd1;
            active_reg    <= NUM_NODE'(8'hFF);
            for (int i = 0; i < NUM_SYM; i++) leaf_reg[i] <= 1'b1;
            state_reg     <= LOAD;
          end
        end
        LOAD: begin
          if (load_cnt_reg == 4'(NUM_SYM)) begin
            merge_cnt_reg <= '0;
            state_reg     <= BUILD;
          end else if (in_valid) begin
            weight_reg[load_cnt_reg[2:0]] <= {3'b000, in_weight};
            load_cnt_reg                  <= load_cnt_reg + 4'd1;
          end
        end
        BUILD: begin
          // Smaller child goes on branch 1, larger on branch 0.
          child1_reg[new_id] <= min_id;
          child0_reg[new_id] <= second_id;
          weight_reg[new_id] <= sum_weight;
          leaf_reg[new_id]   <= 1'b0;
          active_reg[min_id]    <= 1'b0;
          active_reg[second_id] <= 1'b0;
          active_reg[new_id]    <= 1'b1;
          merge_cnt_reg <= merge_cnt_reg + 3'd1;
          if (merge_cnt_reg == 3'd6) begin
            pos_reg   <= ROOT_ID;
            ready     <= 1'b1;
            state_reg <= DECODE;
          end
        end
        DECODE: begin
          if (in_valid) begin
            // New tree arriving: abandon any partial code.
            weight_reg[0] <= {3'b000, in_weight};
            load_cnt_reg  <= 4'd1;
            active_reg    <= NUM_NODE'(8'hFF);
            for (int i = 0; i < NUM_SYM; i++) leaf_reg[i] <= 1'b1;
            pos_reg       <= ROOT_ID;
            ready         <= 1'b0;
            state_reg     <= LOAD;
          end else if (code_valid) begin
            if (leaf_reg[next_node]) begin
              out_valid  <= 1'b1;
              out_symbol <= next_node[2:0];
              pos_reg    <= ROOT_ID;
            end else begin
              pos_reg <= next_node;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ht_decode.sv
// Directed bench for ht_decode with hand-derived Huffman codes.
module tb_ht_decode;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_weight;
  logic       code_valid;
  logic       code_bit;
  logic       ready;
  logic       out_valid;
  logic [2:0] out_symbol;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ht_decode dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_weight  (in_weight),
    .code_valid (code_valid),
    .code_bit   (code_bit),
    .ready      (ready),
    .out_valid  (out_valid),
    .out_symbol (out_symbol)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [2:0] es);
    check({tag, "_valid"}, 8'(out_valid), 8'(ev));
    check({tag, "_sym"}, 8'(out_symbol), 8'(es));
  endtask

  // Weights given as octal digits, symbol 0 first (leftmost).
  task automatic load(input logic [23:0] ws);
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      in_weight = ws[21-3*i +: 3];
      step();
      check("load_ready", 8'(ready), 8'd0);
      check("load_valid", 8'(out_valid), 8'd0);
    end
    in_valid = 1'b0;
    $display("[TB] loaded weights %o", ws);
  endtask

  // Eight cycles until ready; optional code pulses must be ignored.
  task automatic wait_build(input logic poke);
    for (int c = 1; c <= 8; c++) begin
      code_valid = poke;
      code_bit   = 1'b1;
      step();
      check("build_ready", 8'(ready), (c == 8) ? 8'd1 : 8'd0);
      check("build_valid", 8'(out_valid), 8'd0);
    end
    code_valid = 1'b0;
  endtask

  task automatic send(input logic b, input logic ev, input logic [2:0] es, input string tag);
    code_valid = 1'b1;
    code_bit   = b;
    step();
    $display("[TB] bit %0d -> out_valid=%0d out_symbol=%0d", b, out_valid, out_symbol);
    check_out(tag, ev, es);
    code_valid = 1'b0;
  endtask

  task automatic idle(input string tag);
    code_valid = 1'b0;
    step();
    check_out(tag, 1'b0, 3'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_weight = '0; code_valid = 1'b0; code_bit = 1'b0;
    step(); step();
    check("rst_ready", 8'(ready), 8'd0);
    check_out("rst", 1'b0, 3'd0);
    rst = 1'b0;

    // Uniform tree with code pulses during build.
    load(24'o11111111);
    wait_build(1'b1);
    send(1, 0, 0, "u0a"); send(1, 0, 0, "u0b"); send(1, 1, 0, "u_sym0");
    send(1, 0, 0, "u1a"); send(1, 0, 0, "u1b"); send(0, 1, 1, "u_sym1");
    send(0, 0, 0, "u7a"); send(0, 0, 0, "u7b"); send(0, 1, 7, "u_sym7");
    idle("pulse_end");

    // Gaps between bits hold the tree position.
    send(0, 0, 0, "g0");
    for (int k = 0; k < 3; k++) idle("gap_a");
    send(0, 0, 0, "g1");
    for (int k = 0; k < 3; k++) idle("gap_b");
    send(0, 1, 7, "gap_sym7");

    // Partial code then reload with all-zero weights.
    send(1, 0, 0, "p0"); send(1, 0, 0, "p1");
    load(24'o00000000);
    wait_build(1'b0);
    send(1, 0, 0, "z0a"); send(1, 0, 0, "z0b"); send(1, 1, 0, "z_sym0");
    send(0, 0, 0, "z7a"); send(0, 0, 0, "z7b"); send(0, 1, 7, "z_sym7");

    // Skewed tree: symbol 0 has a one-bit code.
    load(24'o71111111);
    wait_build(1'b0);
    send(1, 1, 0, "s_b2b0"); send(1, 1, 0, "s_b2b1"); send(1, 1, 0, "s_b2b2");
    send(0, 0, 0, "s7a"); send(1, 0, 0, "s7b"); send(1, 1, 7, "s_sym7");
    send(0, 0, 0, "s1a"); send(1, 0, 0, "s1b"); send(0, 0, 0, "s1c"); send(1, 1, 1, "s_sym1");

    // Reset during BUILD.
    load(24'o11111111);
    step(); step(); step();
    rst = 1'b1; code_valid = 1'b1;
    step();
    rst = 1'b0; code_valid = 1'b0;
    check("rstb_ready", 8'(ready), 8'd0);
    check_out("rstb", 1'b0, 3'd0);
    for (int k = 0; k < 10; k++) step();
    check("rstb_stay_idle", 8'(ready), 8'd0);

    // Reset mid-code.
    load(24'o11111111);
    wait_build(1'b0);
    send(1, 0, 0, "rc0"); send(1, 0, 0, "rc1");
    rst = 1'b1; code_valid = 1'b1; code_bit = 1'b1;
    step();
    rst = 1'b0; code_valid = 1'b0;
    check("rstc_ready", 8'(ready), 8'd0);
    check_out("rstc", 1'b0, 3'd0);

    // Reset mid-LOAD with in_valid asserted, then a full reload.
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_weight = 3'd5;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("rstl_ready", 8'(ready), 8'd0);
    load(24'o71111111);
    wait_build(1'b0);
    send(1, 1, 0, "rl_sym0");
    send(0, 0, 0, "rl7a"); send(1, 0, 0, "rl7b"); send(1, 1, 7, "rl_sym7");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
